// File: rtl/up_axi_master_pkg.sv
// Shared types and constants for the uP-bus to AXI-lite master bridge.
// Optional build macro: UP_AXI_MASTER_RESP_ERR_EN (adds up_werr/up_rerr).
package up_axi_master_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SEND,
        W_RESP
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_RESP
    } r_state_e;

    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;
    localparam logic [3:0] AXI_WSTRB_FULL   = 4'hF;

endpackage : up_axi_master_pkg

// File: rtl/up_axi_master_rd.sv
// Read path of the uP-bus to AXI-lite master: one AR/R transaction at a time.
// Optional build macro: UP_AXI_MASTER_RESP_ERR_EN (adds up_rerr).
module up_axi_master_rd
    import up_axi_master_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     aclk,
    input  logic                     arstn,
    input  logic                     up_rreq,
    input  logic [ADDRESS_WIDTH-3:0] up_raddr,
    output logic [31:0]              up_rdata,
    output logic                     up_rack,
    output logic                     up_rbusy,
`ifdef UP_AXI_MASTER_RESP_ERR_EN
    output logic                     up_rerr,
`endif
    output logic                     m_axi_arvalid,
    output logic [ADDRESS_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]               m_axi_arprot,
    input  logic                     m_axi_arready,
    input  logic                     m_axi_rvalid,
    input  logic [31:0]              m_axi_rdata,
    input  logic [1:0]               m_axi_rresp,
    output logic                     m_axi_rready
);

    r_state_e                 r_state_q;
    logic                     arvalid_q;
    logic [ADDRESS_WIDTH-1:0] araddr_q;
    logic                     rready_q;
    logic [31:0]              rdata_q;
    logic                     rack_q;
    logic                     rerr_q;

    // Read FSM: AR issue, R capture, one-cycle ack; every AXI output is a flop.
    // NOTE: state is updated with non-blocking assignments so every branch sees
    // the values from the start of the cycle, independent of statement order.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_state_q <= R_IDLE;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            rready_q  <= 1'b0;
            rdata_q   <= '0;
            rack_q    <= 1'b0;
            rerr_q    <= 1'b0;
        end else begin
            rack_q <= 1'b0;
            rerr_q <= 1'b0;
            case (r_state_q)
                R_IDLE: begin
                    if (up_rreq) begin
                        araddr_q  <= {up_raddr, 2'b00};
                        arvalid_q <= 1'b1;
                        r_state_q <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        r_state_q <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (m_axi_rvalid) begin
                        rdata_q   <= m_axi_rdata;
                        rready_q  <= 1'b0;
                        rack_q    <= 1'b1;
                        rerr_q    <= (m_axi_rresp != AXI_RESP_OKAY);
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign up_rdata      = rdata_q;
    assign up_rack       = rack_q;
    assign up_rbusy      = (r_state_q != R_IDLE);
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arprot  = AXI_PROT_DEFAULT;
    assign m_axi_rready  = rready_q;

`ifdef UP_AXI_MASTER_RESP_ERR_EN
    assign up_rerr = rerr_q;
`else
    // Without error reporting the response code has no consumer.
    logic unused_rerr;
    assign unused_rerr = rerr_q;
`endif

endmodule : up_axi_master_rd

// File: rtl/up_axi_master.sv
// uP register bus to AXI-lite master bridge. Write path lives here, read path
// in up_axi_master_rd; both run independently with one transaction each.
// Optional build macro: UP_AXI_MASTER_RESP_ERR_EN (adds up_werr/up_rerr).
module up_axi_master
    import up_axi_master_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     aclk,
    input  logic                     arstn,
    input  logic                     up_wreq,
    input  logic [ADDRESS_WIDTH-3:0] up_waddr,
    input  logic [31:0]              up_wdata,
    output logic                     up_wack,
    output logic                     up_wbusy,
    input  logic                     up_rreq,
    input  logic [ADDRESS_WIDTH-3:0] up_raddr,
    output logic [31:0]              up_rdata,
    output logic                     up_rack,
    output logic                     up_rbusy,
`ifdef UP_AXI_MASTER_RESP_ERR_EN
    output logic                     up_werr,
    output logic                     up_rerr,
`endif
    output logic                     m_axi_awvalid,
    output logic [ADDRESS_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]               m_axi_awprot,
    input  logic                     m_axi_awready,
    output logic                     m_axi_wvalid,
    output logic [31:0]              m_axi_wdata,
    output logic [3:0]               m_axi_wstrb,
    input  logic                     m_axi_wready,
    input  logic                     m_axi_bvalid,
    input  logic [1:0]               m_axi_bresp,
    output logic                     m_axi_bready,
    output logic                     m_axi_arvalid,
    output logic [ADDRESS_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]               m_axi_arprot,
    input  logic                     m_axi_arready,
    input  logic                     m_axi_rvalid,
    input  logic [31:0]              m_axi_rdata,
    input  logic [1:0]               m_axi_rresp,
    output logic                     m_axi_rready
);

    w_state_e                 w_state_q;
    logic                     awvalid_q;
    logic [ADDRESS_WIDTH-1:0] awaddr_q;
    logic                     wvalid_q;
    logic [31:0]              wdata_q;
    logic                     bready_q;
    logic                     wack_q;
    logic                     werr_q;

    // A channel is finished once its valid is already down or handshakes now.
    logic aw_done;
    logic w_done;
    assign aw_done = !awvalid_q || m_axi_awready;
    assign w_done  = !wvalid_q  || m_axi_wready;

    // Write FSM: AW and W run independently, then wait for B; outputs are flops.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            w_state_q <= W_IDLE;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            wvalid_q  <= 1'b0;
            wdata_q   <= '0;
            bready_q  <= 1'b0;
            wack_q    <= 1'b0;
            werr_q    <= 1'b0;
        end else begin
            wack_q <= 1'b0;
            werr_q <= 1'b0;
            case (w_state_q)
                W_IDLE: begin
                    if (up_wreq) begin
                        awaddr_q  <= {up_waddr, 2'b00};
                        wdata_q   <= up_wdata;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        w_state_q <= W_SEND;
                    end
                end
                W_SEND: begin
                    if (m_axi_awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (m_axi_wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        bready_q  <= 1'b1;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (m_axi_bvalid) begin
                        bready_q  <= 1'b0;
                        wack_q    <= 1'b1;
                        werr_q    <= (m_axi_bresp != AXI_RESP_OKAY);
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    assign up_wack       = wack_q;
    assign up_wbusy      = (w_state_q != W_IDLE);
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = AXI_PROT_DEFAULT;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = wdata_q;
    // Strobes are all-ones while data is offered and zero otherwise (reset value).
    assign m_axi_wstrb   = {4{wvalid_q}} & AXI_WSTRB_FULL;
    assign m_axi_bready  = bready_q;

`ifdef UP_AXI_MASTER_RESP_ERR_EN
    assign up_werr = werr_q;
`else
    // Without error reporting the response code has no consumer.
    logic unused_werr;
    assign unused_werr = werr_q;
`endif

    up_axi_master_rd #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_rd (
        .aclk          (aclk),
        .arstn         (arstn),
        .up_rreq       (up_rreq),
        .up_raddr      (up_raddr),
        .up_rdata      (up_rdata),
        .up_rack       (up_rack),
        .up_rbusy      (up_rbusy),
`ifdef UP_AXI_MASTER_RESP_ERR_EN
        .up_rerr       (up_rerr),
`endif
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arready (m_axi_arready),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rready  (m_axi_rready)
    );

endmodule : up_axi_master

// File: tb/tb_up_axi_master.sv
// Scoreboard bench for up_axi_master: stimulus pushes expected AXI beats and
// acks into queues, a negedge monitor pops and compares them.
// Optional build macro: UP_AXI_MASTER_RESP_ERR_EN (checks up_werr/up_rerr).
module tb_up_axi_master;

    localparam int AW = 32;

    logic          aclk = 1'b0;
    logic          arstn;
    logic          up_wreq;
    logic [AW-3:0] up_waddr;
    logic [31:0]   up_wdata;
    logic          up_wack;
    logic          up_wbusy;
    logic          up_rreq;
    logic [AW-3:0] up_raddr;
    logic [31:0]   up_rdata;
    logic          up_rack;
    logic          up_rbusy;
`ifdef UP_AXI_MASTER_RESP_ERR_EN
    logic          up_werr;
    logic          up_rerr;
`endif
    logic          m_axi_awvalid;
    logic [AW-1:0] m_axi_awaddr;
    logic [2:0]    m_axi_awprot;
    logic          m_axi_awready;
    logic          m_axi_wvalid;
    logic [31:0]   m_axi_wdata;
    logic [3:0]    m_axi_wstrb;
    logic          m_axi_wready;
    logic          m_axi_bvalid;
    logic [1:0]    m_axi_bresp;
    logic          m_axi_bready;
    logic          m_axi_arvalid;
    logic [AW-1:0] m_axi_araddr;
    logic [2:0]    m_axi_arprot;
    logic          m_axi_arready;
    logic          m_axi_rvalid;
    logic [31:0]   m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rready;

    always #5 aclk = ~aclk;

    up_axi_master #(.ADDRESS_WIDTH(AW)) dut (
        .aclk          (aclk),
        .arstn         (arstn),
        .up_wreq       (up_wreq),
        .up_waddr      (up_waddr),
        .up_wdata      (up_wdata),
        .up_wack       (up_wack),
        .up_wbusy      (up_wbusy),
        .up_rreq       (up_rreq),
        .up_raddr      (up_raddr),
        .up_rdata      (up_rdata),
        .up_rack       (up_rack),
        .up_rbusy      (up_rbusy),
`ifdef UP_AXI_MASTER_RESP_ERR_EN
        .up_werr       (up_werr),
        .up_rerr       (up_rerr),
`endif
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awready (m_axi_awready),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bready  (m_axi_bready),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arready (m_axi_arready),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rready  (m_axi_rready)
    );

    // ---------------- counters and check helpers ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: got an event, expected none", name);
    endtask

    // ---------------- scoreboard queues ----------------
    typedef struct {
        logic [31:0] data;
        logic        err;
    } rexp_t;

    logic [31:0] exp_aw[$];
    logic [31:0] exp_w[$];
    logic [31:0] exp_ar[$];
    logic        exp_wack[$];
    rexp_t       exp_rack[$];

    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int wack_seen = 0, rack_seen = 0;

    // ---------------- AXI-lite slave model ----------------
    // Each ready rises dly cycles after its valid (0 = same cycle); B answers
    // as soon as bready is seen; R answers r_dly cycles after rready rises.
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [1:0]  rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;

    initial begin
        m_axi_awready = 1'b0;
        forever begin
            @(posedge aclk); #1;
            if (!arstn || m_axi_awready) begin
                m_axi_awready = 1'b0;
                aw_cnt = 0;
            end else if (m_axi_awvalid) begin
                if (aw_cnt >= aw_dly) m_axi_awready = 1'b1;
                else aw_cnt++;
            end
        end
    end

    initial begin
        m_axi_wready = 1'b0;
        forever begin
            @(posedge aclk); #1;
            if (!arstn || m_axi_wready) begin
                m_axi_wready = 1'b0;
                w_cnt = 0;
            end else if (m_axi_wvalid) begin
                if (w_cnt >= w_dly) m_axi_wready = 1'b1;
                else w_cnt++;
            end
        end
    end

    initial begin
        m_axi_arready = 1'b0;
        forever begin
            @(posedge aclk); #1;
            if (!arstn || m_axi_arready) begin
                m_axi_arready = 1'b0;
                ar_cnt = 0;
            end else if (m_axi_arvalid) begin
                if (ar_cnt >= ar_dly) m_axi_arready = 1'b1;
                else ar_cnt++;
            end
        end
    end

    initial begin
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
        forever begin
            @(posedge aclk); #1;
            if (!arstn || m_axi_bvalid) begin
                m_axi_bvalid = 1'b0;
                m_axi_bresp  = 2'b00;
            end else if (m_axi_bready) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = bresp_cfg;
            end
        end
    end

    initial begin
        m_axi_rvalid = 1'b0;
        m_axi_rdata  = '0;
        m_axi_rresp  = 2'b00;
        forever begin
            @(posedge aclk); #1;
            if (!arstn || m_axi_rvalid) begin
                m_axi_rvalid = 1'b0;
                m_axi_rdata  = '0;
                m_axi_rresp  = 2'b00;
                r_cnt = 0;
            end else if (m_axi_rready) begin
                if (r_cnt >= r_dly) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = rdata_cfg;
                    m_axi_rresp  = rresp_cfg;
                end else begin
                    r_cnt++;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic        aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
    logic [31:0] aw_prev, w_prev, ar_prev;
    logic        have_rdata = 1'b0;
    logic [31:0] last_rdata;
    rexp_t       rx;

    initial begin
        forever begin
            @(negedge aclk);
            if (!arstn) begin
                aw_pend    = 1'b0;
                w_pend     = 1'b0;
                ar_pend    = 1'b0;
                have_rdata = 1'b0;
            end else begin
                // AW: held until handshake, payload stable, address as queued.
                if (aw_pend) begin
                    check_bit("aw_valid_held", m_axi_awvalid, 1'b1);
                    check("aw_addr_stable", m_axi_awaddr, aw_prev);
                end
                if (m_axi_awvalid && m_axi_awready) begin
                    aw_hs++;
                    if (exp_aw.size() == 0) unexpected("aw_handshake");
                    else check("awaddr", m_axi_awaddr, exp_aw.pop_front());
                    check("awprot", 32'(m_axi_awprot), 32'd0);
                    aw_pend = 1'b0;
                end else begin
                    aw_pend = m_axi_awvalid;
                    aw_prev = m_axi_awaddr;
                end
                // W
                if (w_pend) begin
                    check_bit("w_valid_held", m_axi_wvalid, 1'b1);
                    check("w_data_stable", m_axi_wdata, w_prev);
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    w_hs++;
                    if (exp_w.size() == 0) unexpected("w_handshake");
                    else check("wdata", m_axi_wdata, exp_w.pop_front());
                    check("wstrb", 32'(m_axi_wstrb), 32'hF);
                    w_pend = 1'b0;
                end else begin
                    w_pend = m_axi_wvalid;
                    w_prev = m_axi_wdata;
                end
                // AR
                if (ar_pend) begin
                    check_bit("ar_valid_held", m_axi_arvalid, 1'b1);
                    check("ar_addr_stable", m_axi_araddr, ar_prev);
                end
                if (m_axi_arvalid && m_axi_arready) begin
                    ar_hs++;
                    if (exp_ar.size() == 0) unexpected("ar_handshake");
                    else check("araddr", m_axi_araddr, exp_ar.pop_front());
                    check("arprot", 32'(m_axi_arprot), 32'd0);
                    ar_pend = 1'b0;
                end else begin
                    ar_pend = m_axi_arvalid;
                    ar_prev = m_axi_araddr;
                end
                if (m_axi_bvalid && m_axi_bready) b_hs++;
                if (m_axi_rvalid && m_axi_rready) r_hs++;
                // Write ack
                if (up_wack) begin
                    wack_seen++;
                    check_bit("wbusy_at_wack", up_wbusy, 1'b0);
                    if (exp_wack.size() == 0) unexpected("up_wack");
                    else begin
`ifdef UP_AXI_MASTER_RESP_ERR_EN
                        check_bit("up_werr", up_werr, exp_wack.pop_front());
`else
                        exp_wack.delete(0);
`endif
                    end
                end
                // Read ack, then read data held until the next ack
                if (up_rack) begin
                    rack_seen++;
                    check_bit("rbusy_at_rack", up_rbusy, 1'b0);
                    if (exp_rack.size() == 0) unexpected("up_rack");
                    else begin
                        rx = exp_rack.pop_front();
                        check("up_rdata", up_rdata, rx.data);
`ifdef UP_AXI_MASTER_RESP_ERR_EN
                        check_bit("up_rerr", up_rerr, rx.err);
`endif
                        last_rdata = rx.data;
                        have_rdata = 1'b1;
                    end
                end else if (have_rdata) begin
                    check("up_rdata_held", up_rdata, last_rdata);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge aclk); #1;
        end
    endtask

    // Called at posedge+1; the request cycle is the one in progress.
    task automatic do_write(input logic [AW-3:0] a, input logic [31:0] d,
                            input logic [1:0] resp, input int exp_lat, input string tag);
        int lat;
        bresp_cfg = resp;
        exp_aw.push_back({a, 2'b00});
        exp_w.push_back(d);
        exp_wack.push_back(resp != 2'b00);
        up_wreq  = 1'b1;
        up_waddr = a;
        up_wdata = d;
        @(posedge aclk); #1;
        up_wreq = 1'b0;
        check_bit({tag, "_wbusy_n1"}, up_wbusy, 1'b1);
        check_bit({tag, "_awvalid_n1"}, m_axi_awvalid, 1'b1);
        lat = 1;
        while (!up_wack && lat < 200) begin
            @(posedge aclk); #1;
            lat++;
        end
        check({tag, "_wlatency"}, lat, exp_lat);
        cycles(1);
        check_bit({tag, "_wack_pulse"}, up_wack, 1'b0);
    endtask

    task automatic do_read(input logic [AW-3:0] a, input logic [31:0] d,
                           input logic [1:0] resp, input int exp_lat, input string tag);
        int    lat;
        rexp_t e;
        rdata_cfg = d;
        rresp_cfg = resp;
        exp_ar.push_back({a, 2'b00});
        e.data = d;
        e.err  = (resp != 2'b00);
        exp_rack.push_back(e);
        up_rreq  = 1'b1;
        up_raddr = a;
        @(posedge aclk); #1;
        up_rreq = 1'b0;
        check_bit({tag, "_rbusy_n1"}, up_rbusy, 1'b1);
        check_bit({tag, "_arvalid_n1"}, m_axi_arvalid, 1'b1);
        lat = 1;
        while (!up_rack && lat < 200) begin
            @(posedge aclk); #1;
            lat++;
        end
        check({tag, "_rlatency"}, lat, exp_lat);
        cycles(1);
        check_bit({tag, "_rack_pulse"}, up_rack, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    int aw0, b0, w0, r0;

    initial begin
        arstn    = 1'b0;
        up_wreq  = 1'b0;
        up_waddr = '0;
        up_wdata = '0;
        up_rreq  = 1'b0;
        up_raddr = '0;
        cycles(3);

        // Reset state
        check_bit("rst_awvalid", m_axi_awvalid, 1'b0);
        check_bit("rst_wvalid", m_axi_wvalid, 1'b0);
        check_bit("rst_bready", m_axi_bready, 1'b0);
        check_bit("rst_arvalid", m_axi_arvalid, 1'b0);
        check_bit("rst_rready", m_axi_rready, 1'b0);
        check_bit("rst_wbusy", up_wbusy, 1'b0);
        check_bit("rst_rbusy", up_rbusy, 1'b0);
        check("rst_rdata", up_rdata, 32'h0);
        arstn = 1'b1;
        cycles(2);

        // 1: minimum-latency write, readies immediate
        aw0 = aw_hs; b0 = b_hs;
        do_write(30'h10, 32'hA5A5_1234, 2'b00, 3, "t1");
        cycles(2);
        check("t1_aw_count", aw_hs - aw0, 1);
        check("t1_b_count", b_hs - b0, 1);

        // 2: awready 2 cycles late, wready 5 cycles late -> ack in N+8
        aw_dly = 2; w_dly = 5;
        w0 = wack_seen;
        do_write(30'h2A5, 32'h0F1E_2D3C, 2'b00, 8, "t2");
        cycles(3);
        check("t2_wack_count", wack_seen - w0, 1);
        aw_dly = 0; w_dly = 0;

        // 3: read with R returned 4 cycles after rready -> ack in N+7, then held
        r_dly = 4;
        do_read(30'h3, 32'hDEAD_BEEF, 2'b00, 7, "t3");
        cycles(5);
        check("t3_rdata_after", up_rdata, 32'hDEAD_BEEF);
        r_dly = 0;

        // 3b: boundary addresses at minimum latency
        do_read(30'h3FFF_FFFF, 32'h1357_9BDF, 2'b00, 3, "t3b");
        do_write(30'h0, 32'hFFFF_FFFF, 2'b00, 3, "t3c");

        // 4: simultaneous write+read, then a second write while busy is dropped
        aw0 = aw_hs; w0 = wack_seen; r0 = rack_seen;
        exp_aw.push_back(32'h0000_0080);
        exp_w.push_back(32'h1111_2222);
        exp_wack.push_back(1'b0);
        exp_ar.push_back(32'h0000_0084);
        rx.data = 32'h3333_4444;
        rx.err  = 1'b0;
        exp_rack.push_back(rx);
        rdata_cfg = 32'h3333_4444;
        rresp_cfg = 2'b00;
        bresp_cfg = 2'b00;
        up_wreq = 1'b1; up_waddr = 30'h20; up_wdata = 32'h1111_2222;
        up_rreq = 1'b1; up_raddr = 30'h21;
        cycles(1);
        check_bit("t4_wbusy", up_wbusy, 1'b1);
        check_bit("t4_rbusy", up_rbusy, 1'b1);
        up_rreq = 1'b0;
        up_waddr = 30'h30; up_wdata = 32'h5555_6666;
        cycles(1);
        up_wreq = 1'b0;
        for (int i = 0; i < 50 && !(wack_seen > w0 && rack_seen > r0); i++) cycles(1);
        cycles(4);
        check("t4_wack_count", wack_seen - w0, 1);
        check("t4_rack_count", rack_seen - r0, 1);
        check("t4_aw_count", aw_hs - aw0, 1);

        // 6: non-OKAY responses (flags checked only when error reporting is built in)
        do_write(30'h55, 32'hCAFE_0001, 2'b10, 3, "t6w");
        do_read(30'h56, 32'h8765_4321, 2'b00, 3, "t6r");
        do_read(30'h57, 32'h0BAD_F00D, 2'b11, 3, "t6re");
        bresp_cfg = 2'b00;
        rresp_cfg = 2'b00;

        // 5: reset while in W_SEND abandons the write with no ack
        aw_dly = 5; w_dly = 5;
        aw0 = aw_hs; w0 = wack_seen;
        up_wreq = 1'b1; up_waddr = 30'h44; up_wdata = 32'h7777_8888;
        cycles(1);
        up_wreq = 1'b0;
        cycles(1);
        check_bit("t5_wvalid_before", m_axi_wvalid, 1'b1);
        arstn = 1'b0;
        #1;
        check_bit("t5_awvalid", m_axi_awvalid, 1'b0);
        check_bit("t5_wvalid", m_axi_wvalid, 1'b0);
        check("t5_wstrb", 32'(m_axi_wstrb), 32'd0);
        check("t5_awaddr", m_axi_awaddr, 32'h0);
        check_bit("t5_bready", m_axi_bready, 1'b0);
        check_bit("t5_wbusy", up_wbusy, 1'b0);
        check("t5_rdata", up_rdata, 32'h0);
        cycles(2);
        arstn = 1'b1;
        aw_dly = 0; w_dly = 0;
        cycles(10);
        check("t5_no_wack", wack_seen - w0, 0);
        check("t5_no_aw", aw_hs - aw0, 0);
        do_write(30'h45, 32'h9999_AAAA, 2'b00, 3, "t5f");
        cycles(3);

        check("q_aw_empty", exp_aw.size(), 0);
        check("q_w_empty", exp_w.size(), 0);
        check("q_ar_empty", exp_ar.size(), 0);
        check("q_wack_empty", exp_wack.size(), 0);
        check("q_rack_empty", exp_rack.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global bound in case a wait above is broken by a design fault.
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_up_axi_master
